// File: rtl/dt_stream_dispatcher.sv
// Packet dispatcher: parses a one-word header, then forwards payload lines to one
// cluster or broadcasts them to all. Unsupported packets are drained and counted.
module dt_stream_dispatcher #(
    parameter int DATA_BUS_WIDTH   = 128,
    parameter int NUM_CLUSTERS     = 8,
    parameter int CLUSTER_BITS     = 3,
    parameter int PACKET_SIZE_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BUS_WIDTH-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_BUS_WIDTH-1:0]   out_data,
    output logic [NUM_CLUSTERS-1:0]     out_valid,
    input  logic [NUM_CLUSTERS-1:0]     out_ready,
    output logic                        out_last,
    output logic                        out_is_data,
    output logic                        out_prog_mode,
    output logic                        drop_pulse,
    output logic [15:0]                 drop_count,
    output logic [31:0]                 pkt_count
);

    typedef enum logic [1:0] {
        ST_HEADER,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [PACKET_SIZE_BITS-1:0] r_remCount;
    logic                        r_isData;
    logic                        r_progMode;
    logic                        r_bcast;
    logic [CLUSTER_BITS-1:0]     r_destIdx;

    logic [DATA_BUS_WIDTH-1:0]   r_outData;
    logic [NUM_CLUSTERS-1:0]     r_outValid;
    logic                        r_outLast;
    logic                        r_outIsData;
    logic                        r_outProgMode;
    logic                        r_dropPulse;
    logic [15:0]                 r_dropCount;
    logic [31:0]                 r_pktCount;

    logic [15:0]                 w_type;
    logic [PACKET_SIZE_BITS-1:0] w_len;
    logic [7:0]                  w_dest;
    logic                        w_typeOk;
    logic                        w_bcast;
    logic                        w_destOk;
    logic                        w_supported;
    logic                        w_outConsumed;
    logic                        w_inReady;
    logic                        w_inFire;
    logic                        w_hdrFire;
    logic                        w_lineFire;
    logic                        w_dropFire;
    logic                        w_lastLine;
    logic [NUM_CLUSTERS-1:0]     w_destMask;

    assign w_type      = in_data[15:0];
    assign w_len       = in_data[16 +: PACKET_SIZE_BITS];
    assign w_dest      = in_data[31:24];
    assign w_typeOk    = (w_type == 16'd1) || (w_type == 16'd2) || (w_type == 16'd3);
    assign w_bcast     = (w_dest == 8'hFF);
    assign w_destOk    = w_bcast || ({1'b0, w_dest} < 9'(NUM_CLUSTERS));
    assign w_supported = w_typeOk && w_destOk;

    // A line leaves the output register only when every targeted cluster is ready.
    assign w_outConsumed = ((r_outValid & ~out_ready) == '0);
    assign w_inReady     = !rst && ((r_state == ST_DROP) || w_outConsumed);
    assign in_ready      = w_inReady;
    assign w_inFire      = in_valid && w_inReady;
    assign w_hdrFire     = w_inFire && (r_state == ST_HEADER);
    assign w_lineFire    = w_inFire && (r_state == ST_PAYLOAD);
    assign w_dropFire    = w_inFire && (r_state == ST_DROP);
    assign w_lastLine    = (r_remCount == PACKET_SIZE_BITS'(1));

    always_comb begin
        w_destMask = '0;
        for (int i = 0; i < NUM_CLUSTERS; i++) begin
            w_destMask[i] = r_bcast || (r_destIdx == CLUSTER_BITS'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HEADER;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_HEADER: begin
                if (w_hdrFire && (w_len != '0)) begin
                    w_nextState = w_supported ? ST_PAYLOAD : ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                if (w_lineFire && w_lastLine) begin
                    w_nextState = ST_HEADER;
                end
            end
            ST_DROP: begin
                if (w_dropFire && w_lastLine) begin
                    w_nextState = ST_HEADER;
                end
            end
            default: w_nextState = ST_HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remCount    <= '0;
            r_isData      <= 1'b0;
            r_progMode    <= 1'b0;
            r_bcast       <= 1'b0;
            r_destIdx     <= '0;
            r_outData     <= '0;
            r_outValid    <= '0;
            r_outLast     <= 1'b0;
            r_outIsData   <= 1'b0;
            r_outProgMode <= 1'b0;
            r_dropPulse   <= 1'b0;
            r_dropCount   <= '0;
            r_pktCount    <= '0;
        end else begin
            r_dropPulse <= 1'b0;

            if (w_hdrFire) begin
                r_remCount <= w_len;
                r_isData   <= (w_type == 16'd1);
                r_progMode <= (w_type == 16'd2);
                r_bcast    <= w_bcast;
                r_destIdx  <= w_dest[CLUSTER_BITS-1:0];
                if (!w_supported) begin
                    r_dropPulse <= 1'b1;
                    if (r_dropCount != 16'hFFFF) begin
                        r_dropCount <= r_dropCount + 16'd1;
                    end
                end else if (w_len == '0) begin
                    r_pktCount <= r_pktCount + 32'd1;
                end
            end

            if (w_lineFire || w_dropFire) begin
                r_remCount <= r_remCount - PACKET_SIZE_BITS'(1);
            end

            if (w_lineFire && w_lastLine) begin
                r_pktCount <= r_pktCount + 32'd1;
            end

            // A new line may replace the one being consumed in the same cycle.
            if (w_lineFire) begin
                r_outData     <= in_data;
                r_outValid    <= w_destMask;
                r_outLast     <= w_lastLine;
                r_outIsData   <= r_isData;
                r_outProgMode <= r_progMode;
            end else if (w_outConsumed) begin
                r_outValid <= '0;
            end
        end
    end

    assign out_data      = r_outData;
    assign out_valid     = r_outValid;
    assign out_last      = r_outLast;
    assign out_is_data   = r_outIsData;
    assign out_prog_mode = r_outProgMode;
    assign drop_pulse    = r_dropPulse;
    assign drop_count    = r_dropCount;
    assign pkt_count     = r_pktCount;

endmodule

// File: tb/tb_dt_stream_dispatcher.sv
// Scoreboard bench for dt_stream_dispatcher: directed packets push expected lines,
// a negedge monitor pops and compares each line as the clusters consume it.
module tb_dt_stream_dispatcher;

    localparam int DBW = 128;
    localparam int NC  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [DBW-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [DBW-1:0] out_data;
    logic [NC-1:0]  out_valid;
    logic [NC-1:0]  out_ready;
    logic           out_last;
    logic           out_is_data;
    logic           out_prog_mode;
    logic           drop_pulse;
    logic [15:0]    drop_count;
    logic [31:0]    pkt_count;

    typedef struct packed {
        logic [DBW-1:0] data;
        logic [NC-1:0]  mask;
        logic           last;
        logic           isData;
        logic           prog;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   cyc         = 0;
    int   t0;
    logic prevStalled = 1'b0;
    exp_t prevSnap;

    dt_stream_dispatcher #(
        .DATA_BUS_WIDTH(DBW),
        .NUM_CLUSTERS(NC),
        .CLUSTER_BITS(3),
        .PACKET_SIZE_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .out_is_data(out_is_data),
        .out_prog_mode(out_prog_mode),
        .drop_pulse(drop_pulse),
        .drop_count(drop_count),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DBW-1:0] hdr(input logic [15:0] t, input logic [7:0] len, input logic [7:0] dest);
        return {96'hDEAD_BEEF_0000_0000_5A5A_5A5A, dest, len, t};
    endfunction

    function automatic logic [DBW-1:0] mkLine(input logic [31:0] tag, input logic [31:0] idx);
        return {tag, 64'h0123_4567_89AB_CDEF, idx};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Callers are aligned just after a rising edge so each word is offered exactly once.
    task automatic applyStimulus(input logic [DBW-1:0] word);
        int waitCycles;
        in_data  = word;
        in_valid = 1'b1;
        @(negedge clk);
        waitCycles = 0;
        while (!in_ready && waitCycles < 1000) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL handshake timeout: in_ready=%0b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [DBW-1:0] d, input logic [NC-1:0] m, input logic l, input logic isd, input logic pm);
        exp_t e;
        e.data   = d;
        e.mask   = m;
        e.last   = l;
        e.isData = isd;
        e.prog   = pm;
        expQ.push_back(e);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        checkOutput(name, expQ.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        got = {out_data, out_valid, out_last, out_is_data, out_prog_mode};
        if (rst) begin
            prevStalled = 1'b0;
        end else begin
            if (prevStalled) begin
                assertCount++;
                if (got !== prevSnap) begin
                    failCount++;
                    $display("[TB] FAIL hold: got valid=%0h data=%0h, expected valid=%0h data=%0h",
                             out_valid, out_data, prevSnap.mask, prevSnap.data);
                end
            end
            if (out_valid != '0) begin
                if ((out_valid & ~out_ready) == '0) begin
                    prevStalled = 1'b0;
                    assertCount++;
                    if (expQ.size() == 0) begin
                        failCount++;
                        $display("[TB] FAIL unexpected line: got valid=%0h data=%0h, expected no output", out_valid, out_data);
                    end else begin
                        e = expQ.pop_front();
                        if (got !== e) begin
                            failCount++;
                            $display("[TB] FAIL line: got data=%0h valid=%0h last=%0b isd=%0b pm=%0b, expected data=%0h valid=%0h last=%0b isd=%0b pm=%0b",
                                     got.data, got.mask, got.last, got.isData, got.prog,
                                     e.data, e.mask, e.last, e.isData, e.prog);
                        end
                    end
                end else begin
                    prevStalled = 1'b1;
                    prevSnap    = got;
                end
            end else begin
                prevStalled = 1'b0;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready during rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready after rst", {31'd0, in_ready}, 32'd1);
        checkOutput("out_valid after rst", {24'd0, out_valid}, 32'd0);
        checkOutput("drop_count after rst", {16'd0, drop_count}, 32'd0);
        checkOutput("pkt_count after rst", pkt_count, 32'd0);

        $display("[TB] findex packet to cluster 2");
        syncDrive();
        for (int i = 1; i <= 4; i++) pushExp(mkLine(32'hF1D0_0000, i), 8'h04, (i == 4), 1'b0, 1'b0);
        t0 = cyc;
        applyStimulus(hdr(16'd3, 8'd4, 8'd2));
        for (int i = 1; i <= 4; i++) applyStimulus(mkLine(32'hF1D0_0000, i));
        checkOutput("findex full rate cycles", t0 + 5, cyc);
        waitDrain("findex drained");
        checkOutput("pkt_count after findex", pkt_count, 32'd1);

        $display("[TB] broadcast weights with stalled cluster 5");
        syncDrive();
        for (int i = 1; i <= 3; i++) pushExp(mkLine(32'hB0CA_0000, i), 8'hFF, (i == 3), 1'b0, 1'b1);
        applyStimulus(hdr(16'd2, 8'd3, 8'hFF));
        applyStimulus(mkLine(32'hB0CA_0000, 1));
        applyStimulus(mkLine(32'hB0CA_0000, 2));
        out_ready = 8'hDF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("in_ready while stalled", {31'd0, in_ready}, 32'd0);
            checkOutput("valid while stalled", {24'd0, out_valid}, 32'h0000_00FF);
            checkOutput("data idx while stalled", out_data[31:0], 32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 8'hFF;
        applyStimulus(mkLine(32'hB0CA_0000, 3));
        waitDrain("broadcast drained");
        checkOutput("pkt_count after broadcast", pkt_count, 32'd2);

        $display("[TB] results packet dropped then data packet");
        syncDrive();
        applyStimulus(hdr(16'd4, 8'd6, 8'd0));
        @(negedge clk);
        checkOutput("drop_pulse after results hdr", {31'd0, drop_pulse}, 32'd1);
        checkOutput("drop_count after results hdr", {16'd0, drop_count}, 32'd1);
        syncDrive();
        checkOutput("drop_pulse one cycle", {31'd0, drop_pulse}, 32'd0);
        t0 = cyc;
        for (int i = 1; i <= 6; i++) applyStimulus(mkLine(32'hD0D0_0000, i));
        checkOutput("drop drain cycles", t0 + 6, cyc);
        checkOutput("out_valid during drop", {24'd0, out_valid}, 32'd0);
        pushExp(mkLine(32'hDA7A_0000, 1), 8'h01, 1'b1, 1'b1, 1'b0);
        applyStimulus(hdr(16'd1, 8'd1, 8'd0));
        applyStimulus(mkLine(32'hDA7A_0000, 1));
        waitDrain("data after drop drained");
        checkOutput("pkt_count after data", pkt_count, 32'd3);

        $display("[TB] empty packet then bad destination");
        syncDrive();
        applyStimulus(hdr(16'd1, 8'd0, 8'd0));
        checkOutput("pkt_count after empty pkt", pkt_count, 32'd4);
        applyStimulus(hdr(16'd1, 8'd2, 8'd9));
        @(negedge clk);
        checkOutput("drop_pulse bad dest", {31'd0, drop_pulse}, 32'd1);
        checkOutput("drop_count bad dest", {16'd0, drop_count}, 32'd2);
        syncDrive();
        applyStimulus(mkLine(32'hBAD0_0000, 1));
        applyStimulus(mkLine(32'hBAD0_0000, 2));
        checkOutput("out_valid bad dest", {24'd0, out_valid}, 32'd0);
        checkOutput("pkt_count bad dest", pkt_count, 32'd4);

        $display("[TB] reset in the middle of a packet");
        syncDrive();
        pushExp(mkLine(32'h5E5E_0000, 1), 8'h08, 1'b0, 1'b1, 1'b0);
        applyStimulus(hdr(16'd1, 8'd5, 8'd3));
        applyStimulus(mkLine(32'h5E5E_0000, 1));
        applyStimulus(mkLine(32'h5E5E_0000, 2));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("in_ready mid rst", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("out_valid post rst", {24'd0, out_valid}, 32'd0);
        checkOutput("out_data post rst", out_data[31:0], 32'd0);
        checkOutput("out flags post rst", {29'd0, out_last, out_is_data, out_prog_mode}, 32'd0);
        checkOutput("drop_count post rst", {16'd0, drop_count}, 32'd0);
        checkOutput("pkt_count post rst", pkt_count, 32'd0);
        checkOutput("in_ready post rst", {31'd0, in_ready}, 32'd1);
        syncDrive();
        pushExp(mkLine(32'hAF7E_0000, 1), 8'h02, 1'b1, 1'b1, 1'b0);
        applyStimulus(hdr(16'd1, 8'd1, 8'd1));
        applyStimulus(mkLine(32'hAF7E_0000, 1));
        waitDrain("post reset packet drained");
        checkOutput("pkt_count post reset pkt", pkt_count, 32'd1);

        $display("[TB] maximum length packet to cluster 7");
        syncDrive();
        for (int i = 1; i <= 255; i++) pushExp(mkLine(32'h3A70_0000, i), 8'h80, (i == 255), 1'b1, 1'b0);
        applyStimulus(hdr(16'd1, 8'd255, 8'd7));
        for (int i = 1; i <= 255; i++) applyStimulus(mkLine(32'h3A70_0000, i));
        waitDrain("max length drained");
        checkOutput("pkt_count after max length", pkt_count, 32'd2);

        $display("[TB] drop counter saturation");
        syncDrive();
        for (int i = 0; i < 70000; i++) applyStimulus(hdr(16'd4, 8'd0, 8'd0));
        @(negedge clk);
        checkOutput("drop_count saturated", {16'd0, drop_count}, 32'h0000_FFFF);
        checkOutput("pkt_count after drops", pkt_count, 32'd2);
        checkOutput("scoreboard empty", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
